// File: rtl/proof_addsub_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// proof_addsub_ctrl : operand register file + command FIFO sequencer that
//                     feeds the proof modular add/sub unit.   Rev 1.0
// ----------------------------------------------------------------------------
module proof_addsub_ctrl #(
  parameter int DW     = 256,
  parameter int AW     = 3,
  parameter int FDEPTH = 4,
  parameter int TMO    = 15
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          cmd_vld_i,
  output logic          cmd_rdy_o,
  input  logic          cmd_mode_i,
  input  logic [AW-1:0] cmd_srca_i,
  input  logic [AW-1:0] cmd_srcb_i,
  input  logic [AW-1:0] cmd_dst_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          au_dstr_o,
  output logic          au_mode_o,
  output logic [DW-1:0] au_data_o,
  output logic [DW-1:0] au_datb_o,
  input  logic          au_dend_i,
  input  logic [DW-1:0] au_datc_i,
  output logic          busy_o,
  output logic [15:0]   done_cnt_o,
  output logic          err_o,
  input  logic          err_clr_i
);
  localparam int NREG = 2**AW;
  localparam int PW   = $clog2(FDEPTH);
  localparam int CW   = 3*AW + 1;
  localparam int TW   = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   rf [NREG];
  logic [CW-1:0]   fifo_mem [FDEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [PW:0]     count;
  logic            full, empty, push, pop;
  logic            cur_mode;
  logic [AW-1:0]   cur_a, cur_b, cur_dst;
  logic [DW-1:0]   result;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit, wb, host_we;

  assign full      = (count == (PW+1)'(FDEPTH));
  assign empty     = (count == '0);
  assign push      = cmd_vld_i & ~full;
  assign cmd_rdy_o = ~full;
  assign busy_o    = (state != S_IDLE) | ~empty;
  assign wb        = (state == S_WB);
  // A write-back to the same register takes priority over the host port
  assign host_we   = wr_en_i & ~(wb & (wr_addr_i == cur_dst));

  assign au_dstr_o = (state == S_ISSUE);
  assign au_mode_o = au_dstr_o & cur_mode;
  assign au_data_o = au_dstr_o ? rf[cur_a] : '0;
  assign au_datb_o = au_dstr_o ? rf[cur_b] : '0;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (au_dend_i) begin
          state_nxt = S_WB;
        end else if (tmo_cnt == TW'(TMO - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr] <= {cmd_mode_i, cmd_srca_i, cmd_srcb_i, cmd_dst_i};
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cur_mode   <= 1'b0;
      cur_a      <= '0;
      cur_b      <= '0;
      cur_dst    <= '0;
      tmo_cnt    <= '0;
      result     <= '0;
      done_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (pop) {cur_mode, cur_a, cur_b, cur_dst} <= fifo_mem[rptr];
      if (state == S_ISSUE)                   tmo_cnt <= '0;
      else if (state == S_WAIT && !au_dend_i) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == S_WAIT && au_dend_i) result <= au_datc_i;
      if (wb) done_cnt_o <= done_cnt_o + 16'd1;
      if (tmo_hit)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (host_we) rf[wr_addr_i] <= wr_data_i;
      if (wb)      rf[cur_dst]   <= result;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) rd_data_o <= '0;
    else        rd_data_o <= rf[rd_addr_i];
  end

endmodule
`default_nettype wire

// File: tb/tb_proof_addsub_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for proof_addsub_ctrl: p=97 unit model answering 3 cycles after start,
// directed scenarios followed by randomized command bursts against a command-level model.
module tb_proof_addsub_ctrl;
  localparam int DW = 256, AW = 3, FDEPTH = 4, TMO = 15, P = 97;

  logic          clk = 1'b0, arst = 1'b1;
  logic          cmd_vld = 1'b0, cmd_mode = 1'b0;
  logic [AW-1:0] cmd_srca = '0, cmd_srcb = '0, cmd_dst = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          err_clr = 1'b0;
  logic          cmd_rdy_o, au_dstr_o, au_mode_o, busy_o, err_o;
  logic [DW-1:0] rd_data_o, au_data_o, au_datb_o;
  logic [15:0]   done_cnt_o;

  logic          hold = 1'b0, mdl_dend = 1'b0, inj_dend = 1'b0;
  logic [DW-1:0] mdl_datc = '0, inj_datc = '0, unit_res = '0;
  wire           au_dend = mdl_dend | inj_dend;
  wire  [DW-1:0] au_datc = inj_dend ? inj_datc : mdl_datc;

  proof_addsub_ctrl #(.DW(DW), .AW(AW), .FDEPTH(FDEPTH), .TMO(TMO)) dut (
    .clk_i(clk), .arst_i(arst), .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy_o),
    .cmd_mode_i(cmd_mode), .cmd_srca_i(cmd_srca), .cmd_srcb_i(cmd_srcb), .cmd_dst_i(cmd_dst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_o),
    .au_dstr_o(au_dstr_o), .au_mode_o(au_mode_o), .au_data_o(au_data_o), .au_datb_o(au_datb_o),
    .au_dend_i(au_dend), .au_datc_i(au_datc),
    .busy_o(busy_o), .done_cnt_o(done_cnt_o), .err_o(err_o), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] modop(input logic m, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] x, y, pp;
    pp = (DW+1)'(P);
    x  = {1'b0, a} % pp;
    y  = {1'b0, b} % pp;
    if (!m) return DW'((x + y) % pp);
    return DW'((x + pp - y) % pp);
  endfunction

  typedef struct {
    logic          m;
    logic [AW-1:0] a, b, d;
  } cmd_t;
  cmd_t          exp_q[$];
  logic [DW-1:0] mrf [8];
  logic          model_on = 1'b0;
  int            mdone = 0;

  // Add/sub unit stand-in: answers 3 cycles after the start pulse unless held
  int            unit_cnt = 0, n_dstr = 0, dstr_cyc = -1, prev_dstr_cyc = -1;
  logic [DW-1:0] last_a = '0, last_b = '0;
  logic          last_mode = 1'b0;
  always @(negedge clk or posedge arst) begin
    if (arst) begin
      unit_cnt = 0;
      mdl_dend = 1'b0;
    end else begin
      mdl_dend = 1'b0;
      if (unit_cnt > 0) begin
        unit_cnt--;
        if (unit_cnt == 0 && !hold) begin
          mdl_dend = 1'b1;
          mdl_datc = unit_res;
        end
      end
      if (au_dstr_o) begin
        unit_cnt      = 3;
        unit_res      = modop(au_mode_o, au_data_o, au_datb_o);
        n_dstr++;
        prev_dstr_cyc = dstr_cyc;
        dstr_cyc      = cyc;
        last_a        = au_data_o;
        last_b        = au_datb_o;
        last_mode     = au_mode_o;
        if (model_on) begin
          if (exp_q.size() == 0) begin
            check("rnd_unexpected_issue", 1, 0);
          end else begin
            cmd_t c;
            c = exp_q.pop_front();
            check("rnd_mode", DW'(au_mode_o), DW'(c.m));
            check("rnd_data", au_data_o, mrf[c.a]);
            check("rnd_datb", au_datb_o, mrf[c.b]);
            mrf[c.d] = modop(c.m, mrf[c.a], mrf[c.b]);
            mdone++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] v);
    rd_addr = a;
    @(negedge clk);
    @(negedge clk);
    v = rd_data_o;
    tick();
  endtask

  task automatic push(input logic m, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [AW-1:0] d, output logic acc);
    cmd_vld = 1'b1; cmd_mode = m; cmd_srca = a; cmd_srcb = b; cmd_dst = d;
    @(negedge clk);
    acc = cmd_rdy_o;
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int k = 0;
    @(negedge clk);
    while (busy_o && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(tag, DW'(busy_o), 0);
    tick();
  endtask

  task automatic wait_issue(input int n0, input string tag);
    int k = 0;
    while (n_dstr == n0 && k < 30) begin
      tick();
      k++;
    end
    check(tag, DW'(n_dstr > n0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] v;
    logic          acc;
    int            n0, nacc, t, k;
    logic [15:0]   dc0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", DW'(busy_o), 0);
    check("rst_dstr", DW'(au_dstr_o), 0);
    check("rst_data", au_data_o, 0);
    check("rst_err", DW'(err_o), 0);
    check("rst_done", DW'(done_cnt_o), 0);
    check("rst_rd", rd_data_o, 0);
    tick();
    arst = 1'b0;
    tick();
    check("rst_rdy_after", DW'(cmd_rdy_o), 1);

    // 1: single add
    host_wr(0, 50); host_wr(1, 60);
    n0 = n_dstr;
    push(1'b0, 0, 1, 2, acc);
    check("t1_acc", DW'(acc), 1);
    wait_idle(40, "t1_idle");
    check("t1_ndstr", DW'(n_dstr - n0), 1);
    check("t1_data", last_a, 50);
    check("t1_datb", last_b, 60);
    check("t1_mode", DW'(last_mode), 0);
    check("t1_done", DW'(done_cnt_o), 1);
    rd(2, v); check("t1_rf2", v, 13);

    // 2: dependent pair sub then add
    host_wr(0, 5); host_wr(1, 9);
    n0 = n_dstr;
    push(1'b1, 0, 1, 3, acc);
    push(1'b0, 3, 3, 4, acc);
    wait_idle(60, "t2_idle");
    check("t2_ndstr", DW'(n_dstr - n0), 2);
    check("t2_data", last_a, 93);
    check("t2_datb", last_b, 93);
    check("t2_gap", DW'((dstr_cyc - prev_dstr_cyc) >= 6), 1);
    rd(3, v); check("t2_rf3", v, 93);
    rd(4, v); check("t2_rf4", v, 89);
    check("t2_done", DW'(done_cnt_o), 3);

    // 3: FIFO fill with the unit stalled
    hold = 1'b1;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 0, 1, 7, acc);
      if (acc) nacc++;
    end
    check("t3_accepted", DW'(nacc), 5);
    check("t3_rdy6", DW'(acc), 0);
    wait_idle(150, "t3_idle");
    check("t3_err", DW'(err_o), 1);
    check("t3_done", DW'(done_cnt_o), 3);
    rd(7, v); check("t3_rf7", v, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    @(negedge clk); check("t3_errclr", DW'(err_o), 0);
    tick();

    // 4: timeout timing, set beats clear, then normal operation resumes
    dc0 = done_cnt_o;
    n0  = n_dstr;
    push(1'b0, 0, 1, 6, acc);
    wait_issue(n0, "t4_issue");
    t = dstr_cyc;
    k = 0;
    while (cyc < t + TMO && k < 40) begin tick(); k++; end
    err_clr = 1'b1;
    @(negedge clk); check("t4_err_early", DW'(err_o), 0);
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    check("t4_err_set", DW'(err_o), 1);
    check("t4_busy", DW'(busy_o), 0);
    tick();
    check("t4_done_same", DW'(done_cnt_o), DW'(dc0));
    rd(6, v); check("t4_rf6_same", v, 0);
    hold = 1'b0;
    repeat (4) tick();
    push(1'b0, 0, 1, 6, acc);
    wait_idle(40, "t4_idle");
    rd(6, v); check("t4_rf6", v, 14);
    check("t4_done", DW'(done_cnt_o), DW'(dc0 + 16'd1));
    check("t4_err_sticky", DW'(err_o), 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    @(negedge clk); check("t4_errclr", DW'(err_o), 0);
    tick();

    // 5: asynchronous reset while waiting with two queued commands
    host_wr(5, 77);
    hold = 1'b1;
    n0 = n_dstr;
    push(1'b0, 0, 1, 5, acc);
    push(1'b0, 0, 1, 5, acc);
    push(1'b0, 0, 1, 5, acc);
    wait_issue(n0, "t5_issue");
    tick(); tick();
    arst = 1'b1;
    #2;
    check("t5_busy", DW'(busy_o), 0);
    check("t5_dstr", DW'(au_dstr_o), 0);
    check("t5_datb", au_datb_o, 0);
    check("t5_done", DW'(done_cnt_o), 0);
    check("t5_rd", rd_data_o, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    hold = 1'b0;
    n0 = n_dstr;
    tick();
    inj_dend = 1'b1; inj_datc = 55;
    tick();
    inj_dend = 1'b0;
    repeat (8) tick();
    check("t5_busy_after", DW'(busy_o), 0);
    check("t5_rdy_after", DW'(cmd_rdy_o), 1);
    check("t5_no_issue", DW'(n_dstr - n0), 0);
    check("t5_done_after", DW'(done_cnt_o), 0);
    rd(5, v); check("t5_rf5", v, 0);

    // 6: host write colliding with write-back
    for (int j = 0; j < 2; j++) begin
      logic [AW-1:0] ha;
      ha = (j == 0) ? 3'd2 : 3'd5;
      host_wr(0, 50); host_wr(1, 60);
      n0 = n_dstr;
      push(1'b0, 0, 1, 2, acc);
      wait_issue(n0, "t6_issue");
      t = dstr_cyc;
      k = 0;
      while (cyc < t + 4 && k < 20) begin tick(); k++; end
      wr_en = 1'b1; wr_addr = ha; wr_data = 256'hABCD + DW'(j);
      tick();
      wr_en = 1'b0;
      wait_idle(20, "t6_idle");
      rd(2, v); check("t6_rf2", v, 13);
      if (j == 1) begin
        rd(5, v); check("t6_rf5", v, 256'hABCE);
      end
    end
    check("t6_done", DW'(done_cnt_o), 2);

    // Randomized bursts against the command-level model
    for (int r = 0; r < 8; r++) begin
      v = DW'($urandom_range(0, P - 1));
      host_wr(AW'(r), v);
      mrf[r] = v;
    end
    dc0 = done_cnt_o;
    mdone = 0;
    model_on = 1'b1;
    for (int bI = 0; bI < 8; bI++) begin
      int bn;
      bn = $urandom_range(1, 4);
      for (int c = 0; c < bn; c++) begin
        cmd_t cm;
        cm.m = 1'($urandom_range(0, 1));
        cm.a = AW'($urandom_range(0, 7));
        cm.b = AW'($urandom_range(0, 7));
        cm.d = AW'($urandom_range(0, 7));
        acc = 1'b0;
        k = 0;
        while (!acc && k < 100) begin
          push(cm.m, cm.a, cm.b, cm.d, acc);
          k++;
        end
        if (acc) exp_q.push_back(cm);
        else check("rnd_push_timeout", 0, 1);
      end
      wait_idle(200, "rnd_idle");
      if (bI % 3 == 2) begin
        int ra;
        ra = $urandom_range(0, 7);
        v  = DW'($urandom_range(0, P - 1));
        host_wr(AW'(ra), v);
        mrf[ra] = v;
      end
    end
    model_on = 1'b0;
    check("rnd_queue_drained", DW'(exp_q.size()), 0);
    check("rnd_done", DW'(done_cnt_o), DW'(dc0 + 16'(mdone)));
    for (int r = 0; r < 8; r++) begin
      rd(AW'(r), v);
      check("rnd_rf", v, mrf[r]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
